// File: rtl/detector_test_sequencer.sv
// detector_test_sequencer
// Latches a parallel test word, clears a serial Moore sequence detector,
// shifts the word into it MSB-first and records after which bits the
// detector reported a hit (per-bit map plus saturating count).
module detector_test_sequencer #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [WORD_W-1:0] pattern,
  input  logic              det_out,
  output logic              det_w,
  output logic              det_resetn,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [WORD_W-1:0] hit_map
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WORD_W-1:0] MSB_ONE  = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  // r_sreg runs one shift ahead of the bit currently on det_w: its MSB is
  // the next bit to present, which lets det_w itself be a plain register.
  logic [WORD_W-1:0]  r_sreg;
  logic               r_det_w;
  logic               r_det_resetn;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_hit_count;
  logic [WORD_W-1:0]  r_hit_map;

  logic               w_sample_en;
  logic [IDX_W-1:0]   w_sample_bit;
  logic [WORD_W-1:0]  w_sample_mask;
  logic               w_hit;

  // Decode which pattern bit (if any) the detector output belongs to this cycle.
  always_comb begin
    w_sample_en  = 1'b0;
    w_sample_bit = '0;
    case (r_state)
      S_SHIFT: begin
        if (r_idx != '0) begin
          w_sample_en  = 1'b1;
          w_sample_bit = r_idx - IDX_W'(1);
        end else begin
          w_sample_en  = 1'b0;
          w_sample_bit = '0;
        end
      end
      S_DRAIN: begin
        w_sample_en  = 1'b1;
        w_sample_bit = LAST_IDX;
      end
      default: begin
        w_sample_en  = 1'b0;
        w_sample_bit = '0;
      end
    endcase
    // Bit j of the pattern sits at hit_map[WORD_W-1-j].
    w_sample_mask = MSB_ONE >> w_sample_bit;
    w_hit         = w_sample_en & det_out;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_sreg       <= '0;
      r_det_w      <= 1'b0;
      r_det_resetn <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hit_count  <= '0;
      r_hit_map    <= '0;
    end else begin
      if (w_hit) begin
        r_hit_map <= r_hit_map | w_sample_mask;
        if (r_hit_count != CNT_MAX) begin
          r_hit_count <= r_hit_count + CNT_W'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_CLEAR;
            r_sreg       <= pattern;
            r_hit_count  <= '0;
            r_hit_map    <= '0;
            r_idx        <= '0;
            r_det_resetn <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state      <= S_SHIFT;
          r_det_resetn <= 1'b1;
          r_det_w      <= r_sreg[WORD_W-1];
          r_sreg       <= {r_sreg[WORD_W-2:0], 1'b0};
        end
        S_SHIFT: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_DRAIN;
            r_det_w <= 1'b0;
          end else begin
            r_det_w <= r_sreg[WORD_W-1];
            r_sreg  <= {r_sreg[WORD_W-2:0], 1'b0};
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_idx        <= '0;
          r_sreg       <= '0;
          r_det_w      <= 1'b0;
          r_det_resetn <= 1'b1;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign det_w      = r_det_w;
  assign det_resetn = r_det_resetn;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hit_count  = r_hit_count;
  assign hit_map    = r_hit_map;

endmodule

// File: doc/detector_test_sequencer.md
# detector_test_sequencer

Controller that drives a serial-input Moore sequence detector from a parallel test word. On `start` it latches a WORD_W-bit pattern, clears the detector, shifts the pattern into the detector's serial input MSB-first at one bit per clock, and samples the detector output after every bit. It reports a per-bit hit map and a hit count, then returns to idle. It sits between board-level switches/keys and a detector instance.

## Interface
- WORD_W, 16: pattern length in bits, ≥ 2
- CNT_W, 5: hit counter width, ≥ clog2(WORD_W+1)

- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- pattern  in  WORD_W  test word; latched on the accepted start
- det_out  in  1  detector output, Moore and registered
- det_w  out  1  serial bit to detector
- det_resetn  out  1  detector synchronous active-low clear
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse in DONE
- hit_count  out  CNT_W  number of bits after which det_out was 1
- hit_map  out  WORD_W  bit k = 1 if det_out was 1 after pattern bit k was consumed

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE. Plus a bit index idx with clog2(WORD_W) bits and a shift register sreg with WORD_W bits.
- IDLE to CLEAR when start = 1. On that edge: sreg ← pattern, hit_count ← 0, hit_map ← 0, idx ← 0.
- CLEAR lasts one cycle. det_resetn = 0 and det_w = 0. Next state is SHIFT.
- SHIFT lasts exactly WORD_W cycles, with idx = 0..WORD_W-1.
  - det_w = sreg[WORD_W-1].
  - sreg shifts left by one each edge, filling with 0.
  - When idx ≥ 1, sample det_out for bit idx-1.
  - After idx = WORD_W-1, go to DRAIN.
- DRAIN lasts one cycle. det_w = 0. Sample det_out for the last bit, idx WORD_W-1. Next state is DONE.
- DONE lasts one cycle. done = 1. Next state is IDLE.
- Sampling bit j when det_out = 1:
  - hit_map[WORD_W-1-j] ← 1, so hit_map bits align with pattern bits.
  - hit_count increments, saturating at 2^CNT_W-1.
- hit_count and hit_map hold their values from DONE until the next accepted start.
- det_resetn = 1 in every state except CLEAR. det_w = 0 outside SHIFT.
- start is ignored when state ≠ IDLE. The pattern input may change freely after acceptance.
- Invalid state encodings go to IDLE.

## Timing
- Reset (resetn = 0, asynchronous, takes effect immediately at any point including mid-run):
  - state = IDLE, sreg = 0, idx = 0.
  - det_w = 0, det_resetn = 1, busy = 0, done = 0, hit_count = 0, hit_map = 0.
- All outputs are registered or decoded from state only. No combinational path from start or det_out to any output.
- Let edge 0 be the edge that accepts start. Then:
  - CLEAR occupies cycle 1.
  - Bit j is on det_w in cycle 2+j.
  - Bit j's result is sampled at the end of cycle 3+j.
  - DRAIN occupies cycle WORD_W+2.
  - done is high in cycle WORD_W+3.
  - busy is high in cycles 1..WORD_W+3 and low from cycle WORD_W+4.
- A start held high through DONE is accepted in the first IDLE cycle, so back-to-back runs are WORD_W+4 cycles apart.
- Detector contract: det_out at cycle t reflects the state after consuming det_w from cycle t-1. det_resetn low during CLEAR returns the detector to its initial state on the CLEAR-end edge.

## Test plan
Bench detector model: Moore; output 1 after input suffix 1111 (overlapping) or 1101 (restarting). WORD_W=16, CNT_W=5.
- 16'hF000 → done in cycle 19 after accept; hit_map = 16'h1000; hit_count = 1; det_w shows 1,1,1,1 then twelve 0s in cycles 2..17.
- 16'hFFFF → hit_map = 16'h1FFF; hit_count = 13.
- 16'hDDDD → hit_map = 16'h1111; hit_count = 4. Then 16'h0000 with start held high continuously → second run accepted in the cycle after DONE; results 0/0; done pulses exactly once per run.
- start pulsed in cycles 1, 5 and 17 of a run → ignored. Results and done timing are unchanged from the single-start run.
- resetn low during SHIFT at idx = 7 → immediately busy = 0, det_w = 0, hit_count = 0, hit_map = 0. After release, a new start of 16'hD000 → hit_map = 16'h1000; hit_count = 1.
